md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the execute stage of the pipelined MIPS core. Holds the architectural HI/LO registers and executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. Its mfhi/mflo result travels through the E/M register beside the ALU result, which becomes the data-memory address and the write-back value. It raises `busy` for a fixed number of cycles so that hazard control can stall dependent MD instructions in decode.

## Interface
- `MULT_CYCLES`, default 5: busy duration of mult/multu.
- `DIV_CYCLES`, default 10: busy duration of div/divu.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  one-cycle pulse; launches the operation given by `MD_op`. Meaningful only when `MD_op` is mult/multu/div/divu.
- `MD_op`  in  4  operation code (`MD_none`, `MD_mult`, `MD_multu`, `MD_div`, `MD_divu`, `MD_mthi`, `MD_mtlo`, `MD_mfhi`, `MD_mflo`).
- `A`  in  32  rs operand; also the source for mthi/mtlo.
- `B`  in  32  rt operand.
- `busy`  out  1  operation in flight; reset value 0.
- `HI`  out  32  architectural HI; reset value 0.
- `LO`  out  32  architectural LO; reset value 0.
- `MDout`  out  32  HI for `MD_mfhi`, LO for `MD_mflo`, otherwise 0. Combinational.

## Operation
Two-state FSM:
- IDLE: `busy`=0.
  - `start`=1 with mult/multu/div/divu: compute the 64-bit result into internal temp registers `tHI`/`tLO` in one step.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES` and go to RUN.
  - `MD_mthi`/`MD_mtlo` (no `start` needed): write `A` into HI/LO at this edge.
- RUN: `busy`=1 and `cnt` decrements each edge.
  - At the edge where `cnt`==1: copy `tHI`/`tLO` into HI/LO, clear `cnt`, return to IDLE.
  - `start`, mthi and mtlo arriving during RUN are ignored. Hazard control guarantees they do not occur.

Arithmetic:
- mult: signed 32x32 giving a 64-bit product; HI = [63:32], LO = [31:0].
- multu: same split, unsigned operands.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): `busy` runs its full `DIV_CYCLES`, and HI/LO stay unchanged.

Other rules:
- `MDout` reads the current HI/LO and does not forward `tHI`/`tLO`.
- Reset during RUN: go to IDLE immediately, `busy`=0, HI=LO=0, `cnt`=0, and discard the pending result.
- `start` with `MD_op` outside mult/multu/div/divu does nothing.

## Timing
- `start` sampled at edge T. `busy` is high from T+1 through the edge T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`. HI/LO update and `busy` falls at edge T+N.
- An mfhi in E during cycle T+N+1 sees the new value.
- `busy` is registered. Hazard control stalls on `start | busy`; this block does not generate that term.
- mthi/mtlo in IDLE take effect at the same edge, so an mfhi in the following cycle sees the written value.
- Back-to-back: a `start` sampled in the cycle right after `busy` falls is accepted.

## Structure
- `MD_*` op codes go in the shared `const.v`, next to `DM_*`.
- Result computation may live in an optional combinational sub-module `md_calc`, with inputs (op, A, B) and output {hi, lo, div0}.
- FSM, counter, temp registers and HI/LO stay in `md_unit`.

## Test plan
- mult A=0xFFFFFFFF, B=2: `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Values unchanged while `busy`.
- multu A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div A=0xFFFFFFF9 (-7), B=2: `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=2 gives LO=3, HI=1.
- mthi A=0x12345678, then mflo/mfhi on the next cycles: MDout=0x12345678 for mfhi. Divu by B=0 afterwards: `busy` 10 cycles, HI/LO unchanged.
- Reset asserted (low) in cycle 3 of a div: `busy`=0, HI=LO=0 immediately. No update happens after release.
- `start` (mult) pulsed while `busy` from a prior div: ignored. Only the div result lands, at cycle 10.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared MD op codes, result bundle and FSM states.
// Imported by md_calc, md_unit and the bench.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_none  = 4'd0,
    MD_mult  = 4'd1,
    MD_multu = 4'd2,
    MD_div   = 4'd3,
    MD_divu  = 4'd4,
    MD_mthi  = 4'd5,
    MD_mtlo  = 4'd6,
    MD_mfhi  = 4'd7,
    MD_mflo  = 4'd8
  } md_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } md_res_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_start(
    input md_op_e op
  );
    return (op == MD_mult) || (op == MD_multu) ||
           (op == MD_div)  || (op == MD_divu);
  endfunction

  function automatic logic is_mult(
    input md_op_e op
  );
    return (op == MD_mult) || (op == MD_multu);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: one-step 64-bit mult/div result for md_unit.
// Ports: op, a, b in; res {hi, lo, div0} out.
module md_calc
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_u;
  logic [31:0] r_u;

  always_comb begin
    res    = '0;
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    sgn    = (op == MD_div);
    neg_a  = sgn & a[31];
    neg_b  = sgn & b[31];
    mag_a  = neg_a ? -a : a;
    mag_b  = neg_b ? -b : b;
    q_u    = '0;
    r_u    = '0;
    // signed divide on magnitudes; 0x80000000 survives
    // the negate-back unchanged, giving the wrapped quotient
    if (mag_b != 32'd0) begin
      q_u = mag_a / mag_b;
      r_u = mag_a % mag_b;
    end
    unique case (op)
      MD_mult:  {res.hi, res.lo} = prod_s;
      MD_multu: {res.hi, res.lo} = prod_u;
      MD_div, MD_divu: begin
        res.lo   = (neg_a ^ neg_b) ? -q_u : q_u;
        res.hi   = neg_a ? -r_u : r_u;
        res.div0 = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO registers with fixed-latency mult/div and busy.
// Ports: clk, reset(n), start, MD_op, A, B; busy, HI, LO, MDout.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      MD_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] thi_q, thi_d;
  logic [31:0] tlo_q, tlo_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  md_res_t     res;

  md_calc u_calc (
    .op  (MD_op),
    .a   (A),
    .b   (B),
    .res (res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_md_start(MD_op)) begin
          thi_d   = res.hi;
          tlo_d   = res.lo;
          div0_d  = res.div0;
          cnt_d   = is_mult(MD_op) ? CW'(MULT_CYCLES)
                                   : CW'(DIV_CYCLES);
          state_d = S_RUN;
        end else if (MD_op == MD_mthi) begin
          hi_d = A;
        end else if (MD_op == MD_mtlo) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(1)) begin
          // divide by zero keeps HI/LO but still burns the latency
          if (!div0_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MDout = '0;
    if (MD_op == MD_mfhi) MDout = hi_q;
    else if (MD_op == MD_mflo) MDout = lo_q;
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table, corner sequences and random stream
// against an arithmetic reference model of HI/LO and busy.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  md_op_e      MD_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDout;

  md_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MD_op (MD_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .MDout (MDout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_ok;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void mcalc(input md_op_e op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h,
                                output logic [31:0] l,
                                output bit ok);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    h  = '0;
    l  = '0;
    case (op)
      MD_mult: begin
        sp = sa * sb;
        h = sp[63:32];
        l = sp[31:0];
      end
      MD_multu: begin
        up = ua * ub;
        h = up[63:32];
        l = up[31:0];
      end
      MD_div: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          sp = sa / sb;
          l = sp[31:0];
          sp = sa % sb;
          h = sp[31:0];
        end
      end
      MD_divu: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          up = ua / ub;
          l = up[31:0];
          up = ua % ub;
          h = up[31:0];
        end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    m_rem = 0;
    m_hi  = '0;
    m_lo  = '0;
    m_ok  = 1'b0;
  endtask

  task automatic model_edge();
    bit muldiv;
    muldiv = (MD_op == MD_mult) || (MD_op == MD_multu) ||
             (MD_op == MD_div) || (MD_op == MD_divu);
    if (!reset) model_clear();
    else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_ok) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start && muldiv) begin
      mcalc(MD_op, A, B, m_phi, m_plo, m_ok);
      m_rem = (MD_op == MD_mult || MD_op == MD_multu) ? MC : DC;
    end else if (MD_op == MD_mthi) m_hi = A;
    else if (MD_op == MD_mtlo) m_lo = A;
  endtask

  task automatic tick();
    logic [31:0] md;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    md = (MD_op == MD_mfhi) ? m_hi :
         (MD_op == MD_mflo) ? m_lo : 32'd0;
    check("busy", 32'(busy), 32'(m_rem > 0));
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
    check("MDout", MDout, md);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    MD_op = v.op;
    A     = v.a;
    B     = v.b;
    start = 1'b1;
    tick();
    start = 1'b0;
    MD_op = MD_none;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check({name, "_cycles"}, n, v.cyc);
    check({name, "_hi"}, HI, v.hi);
    check({name, "_lo"}, LO, v.lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vec_t v;

    vecs[0]  = '{MD_mult,  32'hFFFFFFFF, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1]  = '{MD_multu, 32'hFFFFFFFF, 32'd2,
                 32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2]  = '{MD_div,   32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3]  = '{MD_divu,  32'd7, 32'd2,
                 32'd1, 32'd3, DC};
    vecs[4]  = '{MD_div,   32'h80000000, 32'hFFFFFFFF,
                 32'd0, 32'h80000000, DC};
    vecs[5]  = '{MD_mult,  32'h80000000, 32'h80000000,
                 32'h40000000, 32'd0, MC};
    vecs[6]  = '{MD_divu,  32'd100, 32'd0,
                 32'h40000000, 32'd0, DC};
    vecs[7]  = '{MD_div,   32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD, DC};
    vecs[8]  = '{MD_multu, 32'h00010000, 32'h00010000,
                 32'd1, 32'd0, MC};
    vecs[9]  = '{MD_div,   32'hFFFFFFF8, 32'd3,
                 32'hFFFFFFFE, 32'hFFFFFFFE, DC};
    vecs[10] = '{MD_div,   32'd5, 32'd0,
                 32'hFFFFFFFE, 32'hFFFFFFFE, DC};

    reset = 1'b0;
    start = 1'b0;
    MD_op = MD_none;
    A     = '0;
    B     = '0;
    model_clear();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    MD_op = MD_mthi;
    A     = 32'h12345678;
    tick();
    MD_op = MD_mflo;
    #1;
    check("mflo_after_mthi", MDout, 32'hFFFFFFFE);
    tick();
    MD_op = MD_mfhi;
    #1;
    check("mfhi_after_mthi", MDout, 32'h12345678);
    tick();
    MD_op = MD_mtlo;
    A     = 32'hCAFEF00D;
    tick();
    check("mtlo", LO, 32'hCAFEF00D);
    v = '{MD_divu, 32'd9, 32'd0,
          32'h12345678, 32'hCAFEF00D, DC};
    run_vec(v, "divu0");

    MD_op = MD_div;
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    MD_op = MD_none;
    tick();
    tick();
    MD_op = MD_mult;
    A     = 32'd3;
    B     = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    MD_op = MD_none;
    n = 3;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("ignore_start_cycles", n, DC);
    check("ignore_start_hi", HI, 32'd2);
    check("ignore_start_lo", LO, 32'd14);

    MD_op = MD_div;
    A     = 32'd1000;
    B     = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    MD_op = MD_none;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hi", HI, 32'd0);
    check("mid_rst_lo", LO, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      MD_op = md_op_e'(4'($urandom_range(0, 8)));
      A     = $urandom;
      case ($urandom_range(0, 7))
        0: B = 32'd0;
        1: B = 32'($urandom_range(1, 9));
        2: B = 32'hFFFFFFFF;
        default: B = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) A = 32'h80000000;
      tick();
    end
    start = 1'b0;
    MD_op = MD_mfhi;
    for (int i = 0; i < DC + 2; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
